// File: rtl/pc_unit.sv
// Program-counter unit for the RV32I fetch stage: next-PC select, fetch stall,
// trap redirect on misaligned targets, and a circular return-address stack.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [2:0]      sel,
  input  logic            link,
  input  logic [XLEN-1:0] B_imm,
  input  logic [XLEN-1:0] J_imm,
  input  logic [XLEN-1:0] ALU_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign,
  output logic [XLEN-1:0] mis_addr,
  output logic            ras_underflow
);

  localparam int              PW      = $clog2(RAS_DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   C_DEPTH = CW'(RAS_DEPTH);
  localparam logic [XLEN-1:0] C_FOUR  = XLEN'(4);

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JAL  = 3'b010;
  localparam logic [2:0] SEL_JALR = 3'b011;
  localparam logic [2:0] SEL_TRAP = 3'b100;
  localparam logic [2:0] SEL_RET  = 3'b101;

  logic [XLEN-1:0] r_pc;
  logic [PW-1:0]   r_tp;
  logic [CW-1:0]   r_cnt;
  logic            r_mis;
  logic [XLEN-1:0] r_mis_addr;
  logic            r_uflow;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_top;
  logic [XLEN-1:0] w_target;
  logic [PW-1:0]   w_tp_inc;
  logic [PW-1:0]   w_tp_dec;
  logic            w_empty;
  logic            w_full;
  logic            w_mis;
  logic            w_push;
  logic            w_pop;
  logic            w_repl;
  logic            w_uflow;

  always_comb begin
    w_pc_plus4 = r_pc + C_FOUR;
    w_empty    = (r_cnt == '0);
    w_full     = (r_cnt == C_DEPTH);
    w_top      = w_empty ? '0 : r_ras[r_tp];
    w_tp_inc   = r_tp + PW'(1);
    w_tp_dec   = r_tp - PW'(1);

    case (sel)
      SEL_BR:   w_target = r_pc + B_imm;
      SEL_JAL:  w_target = r_pc + J_imm;
      SEL_JALR: w_target = {ALU_out[XLEN-1:1], 1'b0};
      SEL_TRAP: w_target = TRAP_VECTOR;
      // An empty stack cannot supply a return address, so fetch just falls through.
      SEL_RET:  w_target = w_empty ? w_pc_plus4 : w_top;
      default:  w_target = w_pc_plus4;
    endcase

    w_mis   = (w_target[1:0] != 2'b00);
    w_uflow = (sel == SEL_RET) && w_empty;
    w_push  = link && ((sel == SEL_JAL) || (sel == SEL_JALR)) && !w_mis;
    w_repl  = link && (sel == SEL_RET) && !w_empty && !w_mis;
    w_pop   = !link && (sel == SEL_RET) && !w_empty && !w_mis;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_VECTOR;
      r_tp       <= '0;
      r_cnt      <= '0;
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
      r_uflow    <= 1'b0;
    end else if (stall) begin
      r_mis   <= 1'b0;
      r_uflow <= 1'b0;
    end else begin
      r_uflow <= w_uflow;
      if (w_mis) begin
        r_pc       <= TRAP_VECTOR;
        r_mis      <= 1'b1;
        r_mis_addr <= w_target;
      end else begin
        r_pc  <= w_target;
        r_mis <= 1'b0;
        // A push on a full stack overwrites the oldest slot, so the count saturates.
        if (w_push) begin
          r_tp <= w_tp_inc;
          if (!w_full) r_cnt <= r_cnt + CW'(1);
        end else if (w_pop) begin
          r_tp  <= w_tp_dec;
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  // Stack storage is data only; reset clears the count, not the entries.
  always_ff @(posedge clk) begin
    if (!rst && !stall) begin
      if (w_push)      r_ras[w_tp_inc] <= w_pc_plus4;
      else if (w_repl) r_ras[r_tp]     <= w_pc_plus4;
    end
  end

  assign pc_out        = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign ras_top       = w_top;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign misalign      = r_mis & ~stall;
  assign mis_addr      = r_mis_addr;
  assign ras_underflow = r_uflow & ~stall;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pc_unit;

  localparam logic [31:0] RV   = 32'h0;
  localparam logic [31:0] TV   = 32'h100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, stall, link;
  logic [2:0]  sel;
  logic [31:0] B_imm, J_imm, ALU_out;
  logic [31:0] pc_out, pc_plus4, ras_top, mis_addr;
  logic        ras_empty, ras_full, misalign, ras_underflow;

  pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .sel(sel), .link(link),
    .B_imm(B_imm), .J_imm(J_imm), .ALU_out(ALU_out),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign),
    .mis_addr(mis_addr), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: the stack is a plain queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_mis, m_uf;
  logic [31:0] m_mis_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] tgt, p4;
    p4 = m_pc + 32'd4;
    if (rst) begin
      m_pc = RV; m_q.delete(); m_mis = 1'b0; m_uf = 1'b0; m_mis_addr = '0;
    end else if (stall) begin
      m_mis = 1'b0; m_uf = 1'b0;
    end else begin
      case (sel)
        3'd1:    tgt = m_pc + B_imm;
        3'd2:    tgt = m_pc + J_imm;
        3'd3:    tgt = ALU_out & ~32'd1;
        3'd4:    tgt = TV;
        3'd5:    tgt = (m_q.size() > 0) ? m_q[$] : p4;
        default: tgt = p4;
      endcase
      m_uf = (sel == 3'd5) && (m_q.size() == 0);
      if (tgt[1:0] != 2'b00) begin
        m_mis = 1'b1; m_mis_addr = tgt; m_pc = TV;
      end else begin
        m_mis = 1'b0;
        if (link && (sel == 3'd2 || sel == 3'd3)) begin
          m_q.push_back(p4);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
        end else if (sel == 3'd5 && m_q.size() > 0) begin
          if (link) m_q[$] = p4;
          else void'(m_q.pop_back());
        end
        m_pc = tgt;
      end
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, advance the model, settle.
  task automatic cyc(input logic r, input logic s, input logic [2:0] se, input logic lk,
                     input logic [31:0] b, input logic [31:0] j, input logic [31:0] a);
    rst = r; stall = s; sel = se; link = lk; B_imm = b; J_imm = j; ALU_out = a;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out",        pc_out,        m_pc);
      chk("pc_plus4",      pc_plus4,      m_pc + 32'd4);
      chk("ras_top",       ras_top,       (m_q.size() > 0) ? m_q[$] : 32'h0);
      chk("ras_empty",     {31'd0, ras_empty}, {31'd0, m_q.size() == 0});
      chk("ras_full",      {31'd0, ras_full},  {31'd0, m_q.size() == DEPTH});
      chk("misalign",      {31'd0, misalign},  {31'd0, m_mis & ~stall});
      chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_uf & ~stall});
      chk("mis_addr",      mis_addr,      m_mis_addr);
    end
  end

  initial begin
    m_pc = '0; m_mis = 1'b0; m_uf = 1'b0; m_mis_addr = '0;
    // Reset then sequential fetch
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 1, 3'd2, 1, 0, 32'h40, 0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_top", ras_top, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq1", pc_out, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq2", pc_out, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq3", pc_out, 32'hC);
    // Call and return from 0x20
    cyc(0, 0, 3'd1, 0, 32'h14, 0, 0); chk("br_to_20", pc_out, 32'h20);
    cyc(0, 0, 3'd2, 1, 0, 32'h40, 0);
    chk("call_pc", pc_out, 32'h60);
    chk("call_top", ras_top, 32'h24);
    cyc(0, 0, 3'd5, 0, 0, 0, 0);
    chk("ret_pc", pc_out, 32'h24);
    chk("ret_empty", {31'd0, ras_empty}, 32'd1);
    // RAS overflow: five linked JALs from 0x0..0x400
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 3'd2, 1, 0, 32'h100, 0);
    chk("ovf_full", {31'd0, ras_full}, 32'd1);
    cyc(0, 0, 3'd5, 0, 0, 0, 0); chk("pop1", pc_out, 32'h404);
    cyc(0, 0, 3'd5, 0, 0, 0, 0); chk("pop2", pc_out, 32'h304);
    cyc(0, 0, 3'd5, 0, 0, 0, 0); chk("pop3", pc_out, 32'h204);
    cyc(0, 0, 3'd5, 0, 0, 0, 0); chk("pop4", pc_out, 32'h104);
    cyc(0, 0, 3'd5, 0, 0, 0, 0);
    chk("pop5_pc", pc_out, 32'h108);
    chk("pop5_uflow", {31'd0, ras_underflow}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("uflow_pulse_end", {31'd0, ras_underflow}, 32'd0);
    // Misaligned JALR with link leaves the stack alone
    cyc(0, 0, 3'd2, 1, 0, 32'h100, 0);
    chk("push_top", ras_top, 32'h110);
    cyc(0, 0, 3'd3, 1, 0, 0, 32'h1006);
    chk("mis_pc", pc_out, 32'h100);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_addr_lit", mis_addr, 32'h1006);
    chk("mis_top", ras_top, 32'h110);
    cyc(0, 0, 3'd3, 0, 0, 0, 32'h1005);
    chk("jalr_odd_pc", pc_out, 32'h1004);
    chk("jalr_odd_flag", {31'd0, misalign}, 32'd0);
    // Stall versus redirect
    cyc(0, 1, 3'd1, 0, 32'h10, 0, 0); chk("stall1", pc_out, 32'h1004);
    cyc(0, 1, 3'd1, 0, 32'h10, 0, 0); chk("stall2", pc_out, 32'h1004);
    cyc(0, 0, 3'd1, 0, 32'h10, 0, 0); chk("unstall", pc_out, 32'h1014);
    cyc(1, 1, 3'd1, 0, 32'h10, 0, 0); chk("rst_in_stall", pc_out, RV);
    // Wrap-around
    cyc(0, 0, 3'd1, 0, 32'hFFFF_FFFC, 0, 0); chk("to_top", pc_out, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("wrap", pc_out, 32'h0);
    // Pop with link replaces the top entry
    cyc(0, 0, 3'd2, 1, 0, 32'h8, 0); chk("pl_push", ras_top, 32'h4);
    cyc(0, 0, 3'd5, 1, 0, 0, 0);
    chk("pl_pc", pc_out, 32'h4);
    chk("pl_top", ras_top, 32'hC);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, s, lk;
      logic [2:0] se;
      logic [31:0] b, j, a;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 7) == 0);
      se = 3'($urandom_range(0, 7));
      lk = $urandom_range(0, 1) == 1;
      b  = {$urandom_range(0, 1) == 1 ? 22'h3FFFFF : 22'h0, 10'($urandom)} & 32'hFFFF_FFFC;
      j  = {$urandom_range(0, 1) == 1 ? 20'hFFFFF : 20'h0, 12'($urandom)} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) b[1:0] = 2'($urandom);
      if ($urandom_range(0, 7) == 0) j[1:0] = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1] = 1'b0;
      cyc(r, s, se, lk, b, j, a);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
